// File: rtl/pipe_register_pkg.sv
// -----------------------------------------------------------------------------
// pipe_register_pkg
//
// Shared definitions for the elastic pipe register:
//   stage_state_e  - occupancy state of one two-entry skid stage
//   STAGE_DEPTH    - number of words one stage can hold
//   count_width()  - width of the occupancy counter for a given stage count
// -----------------------------------------------------------------------------
package pipe_register_pkg;

    // Occupancy of a single skid stage. ST_ONE means only the main register
    // holds a word; ST_TWO means both main and skid registers hold words.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } stage_state_e;

    // Words held by one stage when full (main + skid).
    localparam int unsigned STAGE_DEPTH = 32'd2;

    // Width needed to represent 0..STAGE_DEPTH*stages inclusive.
    function automatic int unsigned count_width(input int unsigned stages);
        return $clog2(STAGE_DEPTH * stages + 32'd1);
    endfunction

endpackage : pipe_register_pkg

// File: rtl/pipe_register_skid_stage.sv
// -----------------------------------------------------------------------------
// skid_stage
//
// One two-entry elastic stage (main + skid register). The upstream ready is a
// flop, so no combinational path exists from out_ready back to in_ready; the
// skid register absorbs the word that arrives in the cycle where downstream
// stalls and this stage was already holding one word.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   flush     - synchronous discard of held words (data registers keep value)
//   in_valid  - upstream word present
//   in_ready  - stage can accept a word (registered)
//   in_data   - upstream word
//   out_valid - main register holds a word (registered)
//   out_ready - downstream accepts the word
//   out_data  - main register contents, presented even when out_valid is low
// -----------------------------------------------------------------------------
module skid_stage
    import pipe_register_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    stage_state_e     state_r;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    // valid_r mirrors (state_r != ST_EMPTY); ready_r mirrors the inverse of
    // skid-valid (state_r != ST_TWO). Both are kept as flops so the outputs
    // never pass through decode logic.
    logic             valid_r;
    logic             ready_r;
    logic             push_s;
    logic             pop_s;

    assign push_s    = in_valid && ready_r;
    assign pop_s     = valid_r && out_ready;

    assign in_ready  = ready_r;
    assign out_valid = valid_r;
    assign out_data  = main_r;

    // Stage state machine with registered valid/ready and data movement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            main_r  <= RESET_VALUE;
            skid_r  <= RESET_VALUE;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else if (flush) begin
            // Occupancy cleared; data registers intentionally untouched.
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        main_r  <= in_data;
                        state_r <= ST_ONE;
                        valid_r <= 1'b1;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        // Word leaves and a new one takes its place.
                        main_r  <= in_data;
                    end else if (push_s) begin
                        // Downstream stalled: park the new word in skid.
                        skid_r  <= in_data;
                        state_r <= ST_TWO;
                        ready_r <= 1'b0;
                    end else if (pop_s) begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_ONE;
                    end
                end
                ST_TWO: begin
                    // ready_r is low here, so no push can coincide.
                    if (pop_s) begin
                        main_r  <= skid_r;
                        state_r <= ST_ONE;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_TWO;
                    end
                end
                default: begin
                    // Illegal encoding: fall back to a safe empty stage.
                    state_r <= ST_EMPTY;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule : skid_stage

// File: rtl/pipe_register.sv
// -----------------------------------------------------------------------------
// pipe_register
//
// Chain of STAGES two-entry skid stages forming an elastic pipeline with
// capacity 2*STAGES words, full throughput and registered in_ready.
//
// Parameters:
//   WIDTH       - data word width in bits
//   STAGES      - number of skid stages in series
//   RESET_VALUE - value loaded into every data register at reset
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   flush     - synchronous discard of all held words
//   in_valid  / in_ready  / in_data  - upstream handshake (in_ready is a flop)
//   out_valid / out_ready / out_data - downstream handshake
//   count     - number of words currently held
// -----------------------------------------------------------------------------
module pipe_register
    import pipe_register_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        flush,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [WIDTH-1:0]                            in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [WIDTH-1:0]                            out_data,
    output logic [$clog2(STAGE_DEPTH*STAGES + 32'd1)-1:0] count
);

    localparam int unsigned     CNT_W   = count_width(STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STAGE_DEPTH * STAGES);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Inter-stage links: index k is the input side of stage k,
    // index STAGES is the output side of the last stage.
    logic             valid_s [0:STAGES];
    logic             ready_s [0:STAGES];
    logic [WIDTH-1:0] data_s  [0:STAGES];

    logic [CNT_W-1:0] count_r;
    logic             in_hs_s;
    logic             out_hs_s;

    assign valid_s[0]      = in_valid;
    assign data_s[0]       = in_data;
    assign ready_s[STAGES] = out_ready;

    assign in_ready  = ready_s[0];
    assign out_valid = valid_s[STAGES];
    assign out_data  = data_s[STAGES];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            skid_stage #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .in_valid  (valid_s[k]),
                .in_ready  (ready_s[k]),
                .in_data   (data_s[k]),
                .out_valid (valid_s[k+1]),
                .out_ready (ready_s[k+1]),
                .out_data  (data_s[k+1])
            );
        end
    endgenerate

    assign in_hs_s  = in_valid && ready_s[0];
    assign out_hs_s = valid_s[STAGES] && out_ready;

    // Occupancy counter: +1 on input-only handshake, -1 on output-only.
    // The bound checks are defensive; the stage chain cannot exceed them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            count_r <= {CNT_W{1'b0}};
        end else if (in_hs_s && !out_hs_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else if (out_hs_s && !in_hs_s && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule : pipe_register

// File: tb/tb_pipe_register.sv
// -----------------------------------------------------------------------------
// tb_pipe_register
//
// Two instances: u_dut_a (WIDTH=8, STAGES=2, RESET_VALUE=8'hA5) for directed
// scenarios and u_dut_b (WIDTH=8, STAGES=3) for random traffic against a
// queue-based reference model. Inputs change on the falling edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       flush_a, iv_a, ir_a, ov_a, or_a;
    logic [7:0] id_a, od_a;
    logic [2:0] cnt_a;

    logic       flush_b, iv_b, ir_b, ov_b, or_b;
    logic [7:0] id_b, od_b;
    logic [2:0] cnt_b;

    pipe_register #(.WIDTH(8), .STAGES(2), .RESET_VALUE(8'hA5)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush_a),
        .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
        .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
        .count(cnt_a)
    );

    pipe_register #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'h00)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush_b),
        .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
        .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
        .count(cnt_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] q[$];
    logic       hs_in, hs_out, prev_stall;
    logic [7:0] prev_od;
    int         exp_next;
    int         phase;

    initial begin
        rst = 1'b1;
        flush_a = 1'b0; iv_a = 1'b0; id_a = 8'h00; or_a = 1'b0;
        flush_b = 1'b0; iv_b = 1'b0; id_b = 8'h00; or_b = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_ov",  ov_a,  0);
        check_eq("rst_ir",  ir_a,  1);
        check_eq("rst_cnt", cnt_a, 0);
        check_eq("rst_od",  od_a,  8'hA5);
        rst = 1'b0;
        @(negedge clk);

        // Latency: one word through an empty two-stage pipe
        iv_a = 1'b1; id_a = 8'h11; or_a = 1'b1;
        check_eq("lat_ready", ir_a, 1);
        @(negedge clk);
        iv_a = 1'b0;
        check_eq("lat_cnt1",     cnt_a, 1);
        check_eq("lat_ov_early", ov_a,  0);
        @(negedge clk);
        check_eq("lat_ov", ov_a, 1);
        check_eq("lat_od", od_a, 8'h11);
        @(negedge clk);
        check_eq("lat_cnt0",  cnt_a, 0);
        check_eq("lat_ov_lo", ov_a,  0);

        // Fill with downstream stalled: capacity is four words
        or_a = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            iv_a = 1'b1;
            id_a = 8'(k);
            check_eq($sformatf("fill_rdy%0d", k), ir_a, (k <= 4) ? 1 : 0);
            @(negedge clk);
        end
        check_eq("fill_cnt", cnt_a, 4);
        check_eq("fill_ov",  ov_a,  1);
        check_eq("fill_od_stall", od_a, 8'h01);

        // Drain: expect 1..5 in order (word 5 still offered)
        or_a = 1'b1;
        exp_next = 1;
        for (int c = 0; c < 20; c++) begin
            hs_in  = iv_a && ir_a;
            hs_out = ov_a && or_a;
            if (hs_out) begin
                check_eq("fill_order", od_a, exp_next);
                exp_next++;
            end
            @(negedge clk);
            if (hs_in) iv_a = 1'b0;
        end
        check_eq("fill_drained", exp_next, 6);
        check_eq("fill_cnt_end", cnt_a, 0);

        // Streaming: 100 words back-to-back
        for (int c = 0; c <= 101; c++) begin
            if (c >= 2) begin
                check_eq("stream_ov", ov_a, 1);
                check_eq("stream_od", od_a, 8'(c - 2));
            end
            if (c >= 2 && c <= 100) check_eq("stream_cnt", cnt_a, 2);
            if (c < 100) begin
                check_eq("stream_ir", ir_a, 1);
                iv_a = 1'b1;
                id_a = 8'(c);
            end else begin
                iv_a = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("stream_empty_cnt", cnt_a, 0);
        check_eq("stream_empty_ov",  ov_a,  0);

        // Flush with three words held and a competing push of 8'hFF
        or_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv_a = 1'b1;
            id_a = 8'h21 + 8'(k);
            check_eq("flush_fill_ir", ir_a, 1);
            @(negedge clk);
        end
        iv_a = 1'b0;
        check_eq("flush_pre_cnt", cnt_a, 3);
        flush_a = 1'b1; iv_a = 1'b1; id_a = 8'hFF;
        @(negedge clk);
        flush_a = 1'b0; iv_a = 1'b0;
        check_eq("flush_cnt",  cnt_a, 0);
        check_eq("flush_ov",   ov_a,  0);
        check_eq("flush_ir",   ir_a,  1);
        check_eq("flush_hold", od_a,  8'h21);
        or_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("flush_no_ff", ov_a, 0);
        end

        // Reset asserted mid-transfer
        or_a = 1'b0; iv_a = 1'b1; id_a = 8'h31;
        @(negedge clk);
        id_a = 8'h32;
        @(negedge clk);
        iv_a = 1'b0;
        check_eq("mid_pre_cnt", cnt_a, 2);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_ov",  ov_a,  0);
        check_eq("mid_rst_cnt", cnt_a, 0);
        check_eq("mid_rst_ir",  ir_a,  1);
        check_eq("mid_rst_od",  od_a,  8'hA5);
        @(negedge clk);
        rst = 1'b0;
        iv_a = 1'b1; id_a = 8'h77; or_a = 1'b1;
        @(negedge clk);
        iv_a = 1'b0;
        check_eq("mid_post_cnt", cnt_a, 1);
        @(negedge clk);
        check_eq("mid_post_ov", ov_a, 1);
        check_eq("mid_post_od", od_a, 8'h77);
        @(negedge clk);
        check_eq("mid_post_cnt0", cnt_a, 0);

        // Random traffic on the three-stage instance
        q.delete();
        prev_stall = 1'b0;
        prev_od    = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            check_eq("rnd_cnt", cnt_b, q.size());
            check_eq("rnd_cnt_max", (cnt_b <= 3'd6) ? 1 : 0, 1);
            if (q.size() == 0) check_eq("rnd_empty_ov", ov_b, 0);
            if (ov_b && q.size() > 0) check_eq("rnd_data", od_b, q[0]);
            if (q.size() == 6) check_eq("rnd_full_ir", ir_b, 0);
            if (prev_stall) begin
                check_eq("rnd_stall_ov", ov_b, 1);
                check_eq("rnd_stall_od", od_b, prev_od);
            end
            phase = (c / 500) % 3;
            iv_b = ($urandom_range(0, 3) != 0);
            id_b = 8'($urandom);
            case (phase)
                0:       or_b = ($urandom_range(0, 3) == 0);
                1:       or_b = ($urandom_range(0, 3) != 0);
                default: or_b = 1'b1;
            endcase
            flush_b = ($urandom_range(0, 299) == 0);
            hs_in      = iv_b && ir_b;
            hs_out     = ov_b && or_b;
            prev_stall = ov_b && !or_b && !flush_b;
            prev_od    = od_b;
            @(negedge clk);
            if (flush_b) begin
                q.delete();
            end else begin
                if (hs_out) void'(q.pop_front());
                if (hs_in) q.push_back(id_b);
            end
        end
        iv_b = 1'b0; flush_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipe_register

// File: doc/pipe_register.md
PIPE_REGISTER -- requirements
Module: pipe_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data word width in bits (>=1).
REQ-002 The block SHALL have parameter STAGES, default 2, meaning the number of elastic stages in series (>=1).
REQ-003 The block SHALL have parameter RESET_VALUE, default {WIDTH{1'b0}}, meaning the value loaded into every data register at reset.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 The block SHALL have port flush, input, 1, synchronous discard of all held words.
REQ-007 The block SHALL have port in_valid, input, 1, upstream word present.
REQ-008 The block SHALL have port in_ready, output, 1, block can accept a word; driven directly from a flop.
REQ-009 The block SHALL have port in_data, input, WIDTH, upstream word.
REQ-010 The block SHALL have port out_valid, output, 1, word present at the output.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts the word.
REQ-012 The block SHALL have port out_data, output, WIDTH, output word.
REQ-013 The block SHALL have port count, output, $clog2(2*STAGES+1), number of words currently held.

Function
REQ-014 Input handshake SHALL occur when in_valid && in_ready at a rising edge; output handshake when out_valid && out_ready.
REQ-015 Each stage SHALL be a 2-entry skid buffer (main + skid register) with states EMPTY, ONE (main valid) and TWO (main and skid valid).
REQ-016 Stage transitions: EMPTY->ONE on push; ONE->EMPTY on pop without push; ONE->TWO on push without pop; ONE stays ONE on simultaneous push and pop (main reloaded); TWO->ONE on pop (skid moves to main).
REQ-017 A stage SHALL accept a push only when not in TWO, and its ready SHALL be the registered inverse of skid-valid.
REQ-018 Stage k output SHALL feed stage k+1 input; stage 0 SHALL connect to the in_* ports and stage STAGES-1 to the out_* ports.
REQ-019 Minimum latency SHALL be STAGES cycles: a word accepted at edge N is presented on out_valid/out_data after edge N+STAGES-1 when all stages were EMPTY.
REQ-020 Sustained throughput SHALL be one word per cycle while in_valid and out_ready are both held high.
REQ-021 Word order SHALL be preserved; no word SHALL be duplicated or dropped except by flush or reset.
REQ-022 Total capacity SHALL be 2*STAGES words; with out_ready held low, in_ready SHALL deassert after exactly 2*STAGES accepted words.
REQ-023 count SHALL be +1 on input handshake only, -1 on output handshake only, unchanged on both or neither, and never exceed 2*STAGES.
REQ-024 When flush is high at an edge, all stage states SHALL become EMPTY and count SHALL become 0; handshakes in that cycle SHALL be ignored; data registers SHALL hold their values.
REQ-025 out_data SHALL be the stage STAGES-1 main register at all times, including when out_valid is low.
REQ-026 out_data and out_valid SHALL remain stable while out_valid && !out_ready.

Reset
REQ-027 On rst high, all stages SHALL asynchronously become EMPTY, all data registers SHALL become RESET_VALUE, count SHALL become 0, out_valid SHALL become 0 and in_ready SHALL become 1.
REQ-028 Reset asserted mid-transfer SHALL discard all held words; the first word accepted after release SHALL be the first word output.

Structure
REQ-029 The stage-state encoding (EMPTY/ONE/TWO) SHALL be defined in the shared package as a typedef.
REQ-030 One stage SHALL be a sub-module named skid_stage (WIDTH, RESET_VALUE parameters), instantiated STAGES times via generate.
REQ-031 The count logic SHALL reside in pipe_register, not in skid_stage.

Verification
REQ-032 Reset: WIDTH=8, STAGES=2, RESET_VALUE=8'hA5 -> out_valid=0, in_ready=1, count=0, out_data=8'hA5.
REQ-033 Latency: push 8'h11 into empty block with out_ready=1 -> out_valid high with out_data=8'h11 exactly 2 cycles later; count returns to 0.
REQ-034 Fill: out_ready=0, push 8'h01..8'h05 continuously -> 8'h01..8'h04 accepted, in_ready low on 5th attempt, count=4; then out_ready=1 -> outputs 8'h01..8'h05 in order.
REQ-035 Streaming: in_valid=1, out_ready=1 for 100 cycles with incrementing data -> 1 word per cycle, no gaps after initial latency, count constant at 2.
REQ-036 Flush: hold 3 words, assert flush with in_valid=1 and in_data=8'hFF -> next cycle count=0, out_valid=0, 8'hFF never appears at the output.
REQ-037 Random backpressure: random in_valid/out_ready, STAGES=3, 10000 cycles -> scoreboard matches in order and count equals the scoreboard depth every cycle.
